// File: rtl/nw_tile_scheduler_if.sv
// Tile grid bus between the Needleman-Wunsch tile scheduler and the TILE x TILE grid.
// Packed vectors hold element k at bits [k*SWIDTH +: SWIDTH]; top element 0 is the corner.
interface nw_tile_scheduler_if #(
   parameter int TILE   = 4,
   parameter int TW     = 4,
   parameter int SWIDTH = 16
);
   logic                         start;
   logic [TW-1:0]                row;
   logic [TW-1:0]                col;
   logic [(TILE+1)*SWIDTH-1:0]   top;
   logic [TILE*SWIDTH-1:0]       left;
   logic                         done;
   logic [TILE*SWIDTH-1:0]       bottom;
   logic [TILE*SWIDTH-1:0]       right;

   modport master (output start, row, col, top, left, input done, bottom, right);
   modport slave  (input start, row, col, top, left, output done, bottom, right);
endinterface

// File: rtl/nw_tile_scheduler.sv
// Walks an n_tiles x n_tiles grid of NW tiles in row-major order, feeding each tile its
// boundary scores and keeping the DP row at the current tile-row boundary in rowbuf.
module nw_tile_scheduler #(
   parameter int TILE      = 4,
   parameter int MAX_TILES = 8,
   parameter int TW        = 4,
   parameter int SWIDTH    = 16,
   parameter int INDEL     = -1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [TW-1:0]     n_tiles_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [SWIDTH-1:0] score_o,
   nw_tile_scheduler_if.master g
);
   localparam int DEPTH = MAX_TILES * TILE + 1;
   localparam int AW    = $clog2(DEPTH);

   typedef logic signed [SWIDTH-1:0] score_t;
   typedef enum logic [2:0] {S_IDLE, S_INIT, S_ISSUE, S_WAIT, S_STORE, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   n_q, n_d, row_q, row_d, col_q, col_d;
   logic [AW-1:0]   len_q, len_d, init_q, init_d;
   score_t          corner_q, corner_d, score_q, score_d;
   score_t          leftbuf_q [TILE];
   score_t          leftbuf_d [TILE];
   logic            err_q, err_d;
   score_t          rowbuf_q [DEPTH];

   logic [AW-1:0]   base_a, corner_a;
   logic            legal, last_col, last_row, tile_live;
   int              row_base;
   logic [(TILE+1)*SWIDTH-1:0] top_w;
   logic [TILE*SWIDTH-1:0]     left_w;

   function automatic score_t indel_times(input int k);
      return score_t'(INDEL * k);
   endfunction

   assign base_a    = AW'(int'(col_q) * TILE);
   assign corner_a  = base_a + AW'(TILE);
   assign legal     = (n_tiles_i != '0) && (int'(n_tiles_i) <= MAX_TILES);
   assign last_col  = (col_q == n_q - TW'(1));
   assign last_row  = (row_q == n_q - TW'(1));
   assign tile_live = (state_q == S_ISSUE) || (state_q == S_WAIT);

   always_comb row_base = (int'(row_q) + 1) * TILE;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      len_d     = len_q;
      init_d    = init_q;
      row_d     = row_q;
      col_d     = col_q;
      corner_d  = corner_q;
      leftbuf_d = leftbuf_q;
      score_d   = score_q;
      err_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (legal) begin
                  n_d     = n_tiles_i;
                  len_d   = AW'(int'(n_tiles_i) * TILE);
                  init_d  = '0;
                  score_d = '0;
                  state_d = S_INIT;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_INIT: begin
            row_d    = '0;
            col_d    = '0;
            corner_d = '0;
            for (int i = 0; i < TILE; i++) leftbuf_d[i] = indel_times(i + 1);
            if (init_q == len_q) state_d = S_ISSUE;
            else                 init_d  = init_q + AW'(1);
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (g.done) state_d = S_STORE;
         S_STORE: begin
            // Corner of the next tile is read before this edge overwrites that rowbuf entry.
            corner_d = rowbuf_q[corner_a];
            for (int i = 0; i < TILE; i++) leftbuf_d[i] = g.right[i*SWIDTH +: SWIDTH];
            if (!last_col) begin
               col_d   = col_q + TW'(1);
               state_d = S_ISSUE;
            end else if (!last_row) begin
               row_d    = row_q + TW'(1);
               col_d    = '0;
               corner_d = indel_times(row_base);
               for (int i = 0; i < TILE; i++) leftbuf_d[i] = indel_times(row_base + i + 1);
               state_d  = S_ISSUE;
            end else begin
               score_d = g.bottom[(TILE-1)*SWIDTH +: SWIDTH];
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         len_q     <= '0;
         init_q    <= '0;
         row_q     <= '0;
         col_q     <= '0;
         corner_q  <= '0;
         leftbuf_q <= '{default: '0};
         score_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         len_q     <= len_d;
         init_q    <= init_d;
         row_q     <= row_d;
         col_q     <= col_d;
         corner_q  <= corner_d;
         leftbuf_q <= leftbuf_d;
         score_q   <= score_d;
         err_q     <= err_d;
      end
   end

   // NOTE: rowbuf has no reset; INIT rewrites every entry a run can read before ISSUE.
   always_ff @(posedge clk) begin
      if (state_q == S_INIT) begin
         rowbuf_q[init_q] <= indel_times(int'(init_q));
      end else if (state_q == S_STORE) begin
         for (int i = 0; i < TILE; i++)
            rowbuf_q[base_a + AW'(i + 1)] <= g.bottom[i*SWIDTH +: SWIDTH];
         if (last_col && !last_row) rowbuf_q[0] <= indel_times(row_base);
      end
   end

   always_comb begin
      top_w  = '0;
      left_w = '0;
      if (tile_live) begin
         top_w[0 +: SWIDTH] = corner_q;
         for (int k = 0; k < TILE; k++) begin
            top_w[(k+1)*SWIDTH +: SWIDTH] = rowbuf_q[base_a + AW'(k + 1)];
            left_w[k*SWIDTH +: SWIDTH]    = leftbuf_q[k];
         end
      end
   end

   assign g.start = (state_q == S_ISSUE);
   assign g.row   = row_q;
   assign g.col   = col_q;
   assign g.top   = top_w;
   assign g.left  = left_w;

   assign busy_o  = state_q inside {S_INIT, S_ISSUE, S_WAIT, S_STORE};
   assign done_o  = (state_q == S_DONE);
   assign err_o   = err_q;
   assign score_o = score_q;
endmodule

// File: tb/tb_nw_tile_scheduler.sv
// Scoreboard bench: a full-matrix reference H predicts every tile's boundary inputs and the
// final score; a grid responder answers each tile either from H (markers) or by real tile DP.
module tb_nw_tile_scheduler;
   localparam int TILE = 4, MAX_TILES = 8, TW = 4, SWIDTH = 16, INDEL = -1;
   localparam int MAXN  = MAX_TILES * TILE;
   localparam int TOPW  = (TILE + 1) * SWIDTH;
   localparam int EDGEW = TILE * SWIDTH;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start_i = 1'b0;
   logic [TW-1:0]     n_tiles_i = '0;
   logic              busy_o, done_o, err_o;
   logic [SWIDTH-1:0] score_o;

   always #5 clk = ~clk;

   nw_tile_scheduler_if #(.TILE(TILE), .TW(TW), .SWIDTH(SWIDTH)) gif ();

   logic             resp_done = 1'b0, poke_done = 1'b0;
   logic [EDGEW-1:0] resp_bottom = '0, resp_right = '0;
   assign gif.done   = resp_done | poke_done;
   assign gif.bottom = resp_bottom;
   assign gif.right  = resp_right;

   nw_tile_scheduler #(.TILE(TILE), .MAX_TILES(MAX_TILES), .TW(TW), .SWIDTH(SWIDTH),
                       .INDEL(INDEL)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .n_tiles_i(n_tiles_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .score_o(score_o), .g(gif));

   typedef struct {
      int               row;
      int               col;
      logic [TOPW-1:0]  top;
      logic [EDGEW-1:0] left;
   } tile_exp_t;

   int                total = 0, bad = 0;
   int                H [MAXN+1][MAXN+1];
   byte               s1 [MAXN];
   byte               s2 [MAXN];
   int                mode = 0;          // 0: grid answers from H, 1: grid computes tile DP
   int                lat_override = 0;
   tile_exp_t         exp_q [$];
   logic [SWIDTH-1:0] exp_score_q [$];
   int                exp_err = 0;
   bit                busy_chk = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [SWIDTH-1:0] s16(input int v);
      return v[SWIDTH-1:0];
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   function automatic void build_marker(input int n);
      for (int y = 0; y <= n * TILE; y++)
         for (int x = 0; x <= n * TILE; x++)
            H[y][x] = (y == 0) ? INDEL * x : (x == 0) ? INDEL * y
                                            : int'($urandom_range(0, 200)) - 100;
   endfunction

   // Plain full-matrix global alignment: match +1, mismatch -1, gap INDEL.
   function automatic void build_dp(input int n);
      for (int y = 0; y <= n * TILE; y++)
         for (int x = 0; x <= n * TILE; x++)
            if (y == 0)      H[y][x] = INDEL * x;
            else if (x == 0) H[y][x] = INDEL * y;
            else H[y][x] = max3(H[y-1][x-1] + ((s1[y-1] == s2[x-1]) ? 1 : -1),
                                H[y-1][x] + INDEL, H[y][x-1] + INDEL);
   endfunction

   function automatic void push_expected(input int n);
      tile_exp_t e;
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++) begin
            e.row = r;
            e.col = c;
            for (int k = 0; k <= TILE; k++) e.top[k*SWIDTH +: SWIDTH] = s16(H[r*TILE][c*TILE+k]);
            for (int i = 0; i < TILE; i++)  e.left[i*SWIDTH +: SWIDTH] = s16(H[r*TILE+1+i][c*TILE]);
            exp_q.push_back(e);
         end
      exp_score_q.push_back(s16(H[n*TILE][n*TILE]));
   endfunction

   function automatic void random_strings();
      for (int i = 0; i < MAXN; i++) begin
         s1[i] = byte'($urandom_range(0, 3));
         s2[i] = byte'($urandom_range(0, 3));
      end
   endfunction

   // Grid responder
   initial begin : responder
      int r, c, d;
      bit abort;
      logic [TOPW-1:0]  top_v;
      logic [EDGEW-1:0] left_v, bot, rgt;
      int t [TILE+1][TILE+1];
      forever begin
         @(negedge clk);
         if (!reset && gif.start) begin
            r = int'(gif.row);
            c = int'(gif.col);
            top_v = gif.top;
            left_v = gif.left;
            bot = '0;
            rgt = '0;
            if (r < MAX_TILES && c < MAX_TILES) begin
               if (mode == 0) begin
                  for (int j = 0; j < TILE; j++) begin
                     bot[j*SWIDTH +: SWIDTH] = s16(H[(r+1)*TILE][c*TILE+1+j]);
                     rgt[j*SWIDTH +: SWIDTH] = s16(H[r*TILE+1+j][(c+1)*TILE]);
                  end
               end else begin
                  for (int k = 0; k <= TILE; k++) t[0][k] = $signed(top_v[k*SWIDTH +: SWIDTH]);
                  for (int i = 0; i < TILE; i++) t[i+1][0] = $signed(left_v[i*SWIDTH +: SWIDTH]);
                  for (int i = 1; i <= TILE; i++)
                     for (int j = 1; j <= TILE; j++)
                        t[i][j] = max3(t[i-1][j-1] +
                                       ((s1[r*TILE+i-1] == s2[c*TILE+j-1]) ? 1 : -1),
                                       t[i-1][j] + INDEL, t[i][j-1] + INDEL);
                  for (int j = 0; j < TILE; j++) begin
                     bot[j*SWIDTH +: SWIDTH] = s16(t[TILE][j+1]);
                     rgt[j*SWIDTH +: SWIDTH] = s16(t[j+1][TILE]);
                  end
               end
            end
            d = (lat_override > 0) ? lat_override : int'($urandom_range(1, 4));
            abort = 1'b0;
            repeat (d) begin
               @(negedge clk);
               if (reset) abort = 1'b1;
            end
            if (!abort) begin
               resp_bottom = bot;
               resp_right  = rgt;
               resp_done   = 1'b1;
               @(negedge clk);
               resp_done   = 1'b0;
            end
         end
      end
   end

   // Monitor: compares whatever the DUT presents against the scoreboard queues.
   always @(negedge clk) begin : monitor
      tile_exp_t e;
      if (!reset) begin
         if (busy_chk) begin
            check("busy_after_done", busy_o, 0);
            busy_chk = 1'b0;
         end
         if (gif.start) begin
            check("tile_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("tile_row", gif.row, e.row[TW-1:0]);
               check("tile_col", gif.col, e.col[TW-1:0]);
               check("tile_top", gif.top, e.top);
               check("tile_left", gif.left, e.left);
            end
         end
         if (done_o) begin
            check("score_pending", exp_score_q.size() > 0, 1);
            if (exp_score_q.size() > 0) check("score", score_o, exp_score_q.pop_front());
            busy_chk = 1'b1;
         end
         if (err_o) begin
            check("err_expected", exp_err > 0, 1);
            if (exp_err > 0) exp_err--;
         end
      end
   end

   task automatic launch(input int n);
      @(negedge clk);
      start_i   = 1'b1;
      n_tiles_i = n[TW-1:0];
      @(negedge clk);
      start_i   = 1'b0;
   endtask

   task automatic wait_idle();
      int cyc = 0;
      while ((exp_score_q.size() > 0 || exp_q.size() > 0) && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      check("run_completed", exp_score_q.size() + exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic run(input int n, input int m);
      mode = m;
      push_expected(n);
      launch(n);
      check("busy_after_start", busy_o, 1);
      check("score_cleared", score_o, 0);
      wait_idle();
   endtask

   task automatic illegal(input int n);
      exp_err++;
      launch(n);
      check("busy_illegal", busy_o, 0);
      repeat (3) @(negedge clk);
      check("err_seen", exp_err, 0);
      check("busy_after_err", busy_o, 0);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_err"}, err_o, 0);
      check({tag, "_gstart"}, gif.start, 0);
      check({tag, "_row"}, gif.row, 0);
      check({tag, "_col"}, gif.col, 0);
      check({tag, "_top"}, gif.top, 0);
      check({tag, "_left"}, gif.left, 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int cyc;
      repeat (2) @(negedge clk);
      check_quiet("reset");
      check("reset_score", score_o, 0);
      reset = 1'b0;
      @(negedge clk);
      check_quiet("post_reset");

      poke_done = 1'b1;
      @(negedge clk);
      poke_done = 1'b0;
      check_quiet("idle_grid_done");
      @(negedge clk);
      check_quiet("idle_grid_done2");

      // Single tile with known bottom row {5,6,7,3}
      build_marker(1);
      H[4][1] = 5; H[4][2] = 6; H[4][3] = 7; H[4][4] = 3;
      run(1, 0);
      check("single_score_held", score_o, 16'd3);

      build_marker(2);
      run(2, 0);

      for (int i = 0; i < 8; i++) begin
         s1[i] = byte'($urandom_range(0, 3));
         s2[i] = s1[i];
      end
      build_dp(2);
      run(2, 1);
      check("identical_score", score_o, s16(8));

      for (int i = 0; i < 8; i++) begin
         s1[i] = 8'd0;
         s2[i] = 8'd1;
      end
      build_dp(2);
      run(2, 1);
      check("mismatch_score", score_o, s16(-8));

      illegal(0);
      illegal(9);
      illegal(15);

      // Start during WAIT must be ignored
      build_marker(2);
      lat_override = 6;
      mode = 0;
      push_expected(2);
      launch(2);
      cyc = 0;
      while (exp_q.size() > 3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("reached_first_wait", exp_q.size(), 3);
      @(negedge clk);
      start_i   = 1'b1;
      n_tiles_i = 4'd1;
      @(negedge clk);
      start_i   = 1'b0;
      lat_override = 0;
      wait_idle();

      // Reset during WAIT of tile (0,1)
      build_marker(2);
      lat_override = 30;
      push_expected(2);
      launch(2);
      cyc = 0;
      while (exp_q.size() > 2 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("reached_tile01", exp_q.size(), 2);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", busy_o, 0);
      check("abort_gstart", gif.start, 0);
      check("abort_done", done_o, 0);
      @(negedge clk);
      exp_q.delete();
      exp_score_q.delete();
      lat_override = 0;
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_stays_idle", busy_o, 0);
      random_strings();
      build_dp(2);
      run(2, 1);

      build_marker(MAX_TILES);
      run(MAX_TILES, 0);

      for (int it = 0; it < 6; it++) begin
         int n, m;
         n = int'($urandom_range(1, 3));
         m = int'($urandom_range(0, 1));
         random_strings();
         if (m == 1) build_dp(n);
         else        build_marker(n);
         run(n, m);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/nw_tile_scheduler.md
Name: nw_tile_scheduler

Overview:
Sequences one fixed-size TILE x TILE Needleman-Wunsch grid over an (n_tiles*TILE) x (n_tiles*TILE) score matrix. Tiles run in row-major order.
For each tile it does three things: presents the top and left boundary scores, pulses the grid start, and waits for the grid's done signal. It then captures the bottom and right scores into internal boundary buffers.
It sits between the top-level sequencer and the grid. The final bottom-right cell score is reported as the alignment score.

Parameters:
TILE, 4, characters per tile edge (grid LENGTH)
MAX_TILES, 8, maximum tiles per matrix edge
TW, 4, width of n_tiles and tile index ports (must hold MAX_TILES)
SWIDTH, 16, signed score width
INDEL, -1, signed gap weight used for matrix edge initialisation

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin alignment; sampled only in IDLE
n_tiles  in  TW  tiles per edge, legal range 1..MAX_TILES; sampled with start
busy  out  1  high from accepted start until the done pulse
done  out  1  one-cycle pulse when score is valid
err  out  1  one-cycle pulse: start with illegal n_tiles
score  out  SWIDTH  final alignment score, signed
grid_start  out  1  one-cycle pulse launching a tile
grid_row  out  TW  current tile row (selects the s1 slice)
grid_col  out  TW  current tile column (selects the s2 slice)
grid_top  out  (TILE+1)*SWIDTH  element 0 = corner, elements 1..TILE = above scores
grid_left  out  TILE*SWIDTH  left scores, element 0 = topmost
grid_done  in  1  grid finished the current tile
grid_bottom  in  TILE*SWIDTH  bottom-row scores of the finished tile
grid_right  in  TILE*SWIDTH  right-column scores of the finished tile

Behaviour:
- Reset:
  - Outputs: busy=0, done=0, err=0, score=0, grid_start=0, grid_row=0, grid_col=0, grid_top=0, grid_left=0.
  - State goes to IDLE.
  - Reset asserted mid-operation abandons the run. Any later grid_done is ignored.
- Storage:
  - rowbuf: MAX_TILES*TILE+1 signed scores holding DP row r*TILE.
  - leftbuf: TILE scores.
  - corner: a single register.
- States and transitions:
  - IDLE:
    - start with n_tiles=0 or >MAX_TILES: pulse err next cycle, stay IDLE.
    - start with legal n_tiles: latch N=n_tiles*TILE, set busy, go to INIT.
    - start while not IDLE is ignored.
  - INIT: one cycle per index.
    - Writes rowbuf[x]=INDEL*x for x=0..N (N+1 cycles).
    - Sets row=0 and col=0, corner=0, and leftbuf[i]=INDEL*(i+1).
    - Then goes to ISSUE.
  - ISSUE (1 cycle):
    - Drive grid_top = {corner, rowbuf[col*TILE+1 .. col*TILE+TILE]}, grid_left = leftbuf, and grid_row/grid_col.
    - Pulse grid_start.
    - Go to WAIT.
  - WAIT:
    - grid_top, grid_left, grid_row and grid_col are held stable.
    - On grid_done, go to STORE. grid_done in any other state is ignored.
    - grid_done may arrive as early as the cycle after grid_start.
  - STORE (1 cycle), at the same edge:
    - Capture the old rowbuf[(col+1)*TILE] into corner, before it is overwritten.
    - Write grid_bottom into rowbuf[col*TILE+1..col*TILE+TILE].
    - Copy grid_right into leftbuf.
    - If col<n_tiles-1: col++ and go to ISSUE.
    - Else if row<n_tiles-1: row++, col=0; corner=INDEL*row_new*TILE (old rowbuf[0] value); rowbuf[0]=INDEL*(row_new*TILE); leftbuf[i]=INDEL*(row_new*TILE+i+1); go to ISSUE.
    - Else: score=grid_bottom[TILE-1] and go to DONE.
  - DONE (1 cycle): pulse done, clear busy, return to IDLE.
- Score and timing:
  - score holds until the next accepted start, then clears to 0.
  - Arithmetic is signed, SWIDTH-bit products truncated to SWIDTH.
  - Latency from start to done = 1 + (N+1) + sum over tiles of (2 + grid wait) + 1 cycles.

Test Plan:
- Reset check: assert reset for 2 cycles -> all outputs 0, busy=0; a grid_done pulse produces no state change.
- Single tile (TILE=4, INDEL=-1, n_tiles=1), grid model returns bottom={5,6,7,3}:
  - First ISSUE grid_top = {0,-1,-2,-3,-4}, grid_left = {-1,-2,-3,-4}, row=col=0.
  - score=3, done pulses once, busy falls with done.
- 2x2 tiles, grid model echoing markers, run against a golden model:
  - Tile order is (0,0),(0,1),(1,0),(1,1).
  - Tile (1,0) corner=-4 and left={-5,-6,-7,-8}.
  - Tile (1,1) corner = tile(0,0) bottom[3], top[1..4] = tile(0,1) bottom, left = tile(1,0) right.
- Full alignment with the behavioural grid: identical 8-char strings -> score=8; all-mismatch strings -> score=-8.
- Illegal and ignored starts:
  - n_tiles=0 -> err pulse, busy stays 0.
  - n_tiles=9 -> err pulse.
  - start during WAIT -> ignored; the run completes with unchanged score.
- Reset during WAIT of tile (0,1) -> IDLE next cycle, grid_start low; a following legal start runs cleanly from INIT.
